// File: rtl/data_mem_lsu_if.sv
// Request/response bus between a load/store client and data_mem_lsu.
// The master issues byte/half/word accesses and consumes responses.
// The slave is the memory side.
interface data_mem_lsu_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Word-organised data memory with a byte/half/word load-store front end.
// Each request goes IDLE -> ACCESS -> RESP, so one request is served every
// three cycles at best. Misaligned, illegal-size and out-of-range accesses
// fault without touching the array.
// Optional statistics counters: define DMEM_STATS_EN to enable them.
module data_mem_lsu #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_lsu_if.slave       bus,
  output logic [15:0]         cnt_rd,
  output logic [15:0]         cnt_wr,
  output logic [15:0]         cnt_err
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Word 7 (byte address 28) comes up holding 0x20; reset never clears memory.
  logic [31:0] mem [DEPTH] = '{7: 32'h0000_0020, default: '0};

  logic             hi_fault;
  logic             fault;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word;
  logic [31:0]      shifted;
  logic [31:0]      load_data;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;
  logic             mem_we;

  // Address bits above the array are only present when ADDR_W exceeds the index width.
  if (ADDR_W > IDX_W + 2) begin : g_hi
    assign hi_fault = |addr_q[ADDR_W-1:IDX_W+2];
  end else begin : g_nohi
    assign hi_fault = 1'b0;
  end

  // Fault detection, load alignment/extension and store lane selection.
  always_comb begin
    fault = hi_fault
          | (size_q == 2'b11)
          | ((size_q == 2'b01) & addr_q[0])
          | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00));
    word_idx = addr_q[IDX_W+1:2];
    rd_word  = mem[word_idx];
    shifted  = rd_word >> {addr_q[1:0], 3'b000};
    unique case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = rd_word;
    endcase
    unique case (size_q)
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    unique case (size_q)
      2'b00:   wdata_rep = {4{wdata_q[7:0]}};
      2'b01:   wdata_rep = {2{wdata_q[15:0]}};
      default: wdata_rep = wdata_q;
    endcase
    mem_we = (state_q == S_ACCESS) & we_q & ~fault & ~rst;
  end

  // Byte-lane writes into the array during ACCESS of a good store.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  // Next-state and request capture logic.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    bus.req_ready = (state_q == S_IDLE) & ~rst;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid & bus.req_ready) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        err_d   = fault;
        rdata_d = (fault | we_q) ? '0 : load_data;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response outputs are held by the registers and forced quiet outside RESP.
  always_comb begin
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_rdata = (state_q == S_RESP) ? rdata_q : '0;
    bus.rsp_err   = (state_q == S_RESP) & err_q;
  end

  // State and captured-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef DMEM_STATS_EN
  logic [15:0] cnt_rd_q, cnt_rd_d;
  logic [15:0] cnt_wr_q, cnt_wr_d;
  logic [15:0] cnt_err_q, cnt_err_d;
  logic        rsp_hs;

  assign rsp_hs = (state_q == S_RESP) & bus.rsp_ready;

  // Saturating counters bumped when a response is consumed.
  always_comb begin
    cnt_rd_d  = cnt_rd_q;
    cnt_wr_d  = cnt_wr_q;
    cnt_err_d = cnt_err_q;
    if (rsp_hs) begin
      if (err_q) begin
        if (cnt_err_q != '1) cnt_err_d = cnt_err_q + 16'd1;
      end else if (we_q) begin
        if (cnt_wr_q != '1) cnt_wr_d = cnt_wr_q + 16'd1;
      end else begin
        if (cnt_rd_q != '1) cnt_rd_d = cnt_rd_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_rd_q  <= '0;
      cnt_wr_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      cnt_rd_q  <= cnt_rd_d;
      cnt_wr_q  <= cnt_wr_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign cnt_rd  = cnt_rd_q;
  assign cnt_wr  = cnt_wr_q;
  assign cnt_err = cnt_err_q;
`else
  assign cnt_rd  = '0;
  assign cnt_wr  = '0;
  assign cnt_err = '0;
`endif
endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed requests, a word-array
// reference model with arithmetic byte/half handling, and a per-cycle
// response/counter comparison.
module tb_data_mem_lsu;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cnt_rd, cnt_wr, cnt_err;

  data_mem_lsu_if #(.ADDR_W(ADDR_W)) bus();

  data_mem_lsu #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cnt_rd  (cnt_rd),
    .cnt_wr  (cnt_wr),
    .cnt_err (cnt_err)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic        chk_en = 1'b0;
  exp_t        exp_q[$];
  logic [31:0] mm [DEPTH];
  int unsigned m_rd = 0, m_wr = 0, m_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cexp(input int unsigned c);
`ifdef DMEM_STATS_EN
    return (c > 65535) ? 32'd65535 : c;
`else
    return 32'd0 + 0 * c;
`endif
  endfunction

  // Reference model: returns the expected response and applies good stores.
  function automatic exp_t model_access(input logic we, input logic [1:0] sz, input logic uns,
                                        input logic [31:0] a, input logic [31:0] wd);
    exp_t        r;
    int unsigned off, wi;
    logic [31:0] w, v, mask;
    bit          flt;
    off = a % 4;
    wi  = a / 4;
    flt = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && off != 0)
          || (a >= DEPTH * 4);
    r.rdata = 32'd0;
    r.err   = flt;
    if (flt) return r;
    w = mm[wi];
    if (we) begin
      case (sz)
        2'd0:    mask = 32'h0000_00FF << (8 * off);
        2'd1:    mask = 32'h0000_FFFF << (8 * off);
        default: mask = 32'hFFFF_FFFF;
      endcase
      mm[wi] = (w & ~mask) | ((wd << (8 * off)) & mask);
      return r;
    end
    v = w >> (8 * off);
    case (sz)
      2'd0: begin
        v = v % 256;
        if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = v % 65536;
        if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    r.rdata = v;
    return r;
  endfunction

  // Per-cycle comparison of response outputs and counters.
  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          check("rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
          check("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
        end
      end else begin
        check("idle_rdata", bus.rsp_rdata, 32'd0);
        check("idle_err", 32'(bus.rsp_err), 32'd0);
      end
      check("cnt_rd", 32'(cnt_rd), cexp(m_rd));
      check("cnt_wr", 32'(cnt_wr), cexp(m_wr));
      check("cnt_err", 32'(cnt_err), cexp(m_err));
    end
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int unsigned hold,
                        input logic chk_lit, input logic [31:0] lit_data, input logic lit_err);
    exp_t        e;
    int unsigned n;
    e = model_access(we, sz, uns, a, wd);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    check("lat_access_valid", 32'(bus.rsp_valid), 32'd0);
    check("busy_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("lat_resp_valid", 32'(bus.rsp_valid), 32'd1);
    if (chk_lit) begin
      check("lit_rdata", bus.rsp_rdata, lit_data);
      check("lit_err", 32'(bus.rsp_err), 32'(lit_err));
    end
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    void'(exp_q.pop_front());
    if (e.err) m_err++;
    else if (we) m_wr++;
    else m_rd++;
    @(negedge clk);
    check("post_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_rd = 0; m_wr = 0; m_err = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset lands while the store is in ACCESS: no write and no response.
  task automatic rst_during_store(input logic [31:0] a, input logic [31:0] wd);
    int unsigned n;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 0;
    @(negedge clk);
    check("rst_drop_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_idle_ready", 32'(bus.req_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mm[i] = 32'd0;
    mm[7] = 32'h0000_0020;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rdata", bus.rsp_rdata, 32'd0);
    check("reset_err", 32'(bus.rsp_err), 32'd0);
    check("reset_ready", 32'(bus.req_ready), 32'd0);
    check("reset_cnt_rd", 32'(cnt_rd), 32'd0);
    check("reset_cnt_err", 32'(cnt_err), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Power-up preload, with a five-cycle response stall.
    do_req(1'b0, 2'd2, 1'b0, 32'd28, 32'd0, 5, 1'b1, 32'h0000_0020, 1'b0);

    // Word store and readback.
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, 0, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Byte store; only wdata[7:0] may land.
    do_req(1'b1, 2'd0, 1'b0, 32'h41, 32'h1234_5680, 0, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'h41, 32'd0, 0, 1'b1, 32'hFFFF_FF80, 1'b0);
    do_req(1'b0, 2'd0, 1'b1, 32'h41, 32'd0, 0, 1'b1, 32'h0000_0080, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 0, 1'b1, 32'hDEAD_80EF, 1'b0);

    // Faults: misaligned, out of range, illegal size; memory untouched.
    do_req(1'b0, 2'd1, 1'b0, 32'h43, 32'd0, 0, 1'b1, 32'h0, 1'b1);
    do_req(1'b1, 2'd1, 1'b0, 32'h43, 32'h0000_5555, 0, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'd0, 0, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 0, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'd0, 0, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 0, 1'b1, 32'hDEAD_80EF, 1'b0);

    // Half store on the upper lanes and sub-word loads around it.
    do_req(1'b1, 2'd1, 1'b0, 32'h42, 32'hAAAA_CAFE, 0, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 0, 1'b1, 32'hCAFE_80EF, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'h42, 32'd0, 0, 1'b1, 32'hFFFF_CAFE, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 32'h40, 32'd0, 0, 1'b1, 32'h0000_80EF, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'h40, 32'd0, 0, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'h43, 32'd0, 0, 1'b1, 32'hFFFF_FFCA, 1'b0);
    do_req(1'b0, 2'd0, 1'b1, 32'h40, 32'd0, 0, 1'b0, 32'h0, 1'b0);

    // Reset during a store's ACCESS cycle leaves the word as it was.
    do_req(1'b1, 2'd2, 1'b0, 32'h80, 32'h1111_1111, 0, 1'b0, 32'h0, 1'b0);
    rst_during_store(32'h80, 32'h1234_5678);
    do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'd0, 0, 1'b1, 32'h1111_1111, 1'b0);

    // Counter tally from a clean reset: 3 loads, 2 stores, 1 fault.
    do_reset();
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 0, 1'b0, 32'h0, 1'b0);
    do_req(1'b1, 2'd0, 1'b0, 32'h44, 32'h0000_0033, 0, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b1, 32'h44, 32'd0, 0, 1'b1, 32'h0000_0033, 1'b0);
    do_req(1'b1, 2'd2, 1'b0, 32'h48, 32'h0BAD_F00D, 0, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 2'd3, 1'b0, 32'h48, 32'd0, 0, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'h48, 32'd0, 0, 1'b1, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
`ifdef DMEM_STATS_EN
    check("tally_rd", 32'(cnt_rd), 32'd3);
    check("tally_wr", 32'(cnt_wr), 32'd2);
    check("tally_err", 32'(cnt_err), 32'd1);
`else
    check("tally_rd", 32'(cnt_rd), 32'd0);
    check("tally_wr", 32'(cnt_wr), 32'd0);
    check("tally_err", 32'(cnt_err), 32'd0);
`endif

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
